sfu_ctrl: RTL and testbench

- Sequencer between the output FIFO (OFIFO) and the accumulate/ReLU special function unit (SFU).
- For each output pixel, pops exactly `num_kij` partial-sum words from OFIFO and feeds them to the SFU with acc held high.
- Then triggers one ReLU cycle and issues one write of the SFU result to the output SRAM.
- Owns the SFU control pins so that OFIFO stalls never corrupt an in-progress accumulation.

---
 rtl/sfu_ctrl.sv | 133 +++++++++++++
 tb/tb_sfu_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfu_ctrl.sv
// sfu_ctrl: drains num_kij partial sums per output pixel from the OFIFO into the
// accumulate/ReLU SFU, then triggers ReLU and writes the result to output SRAM.
module sfu_ctrl #(
  parameter int PSUM_BW = 16,
  parameter int COL     = 8,
  parameter int KIJ_W   = 4,
  parameter int ADDR_W  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KIJ_W-1:0]       num_kij,
  input  logic [ADDR_W-1:0]      num_out,
  input  logic                   ofifo_empty,
  input  logic [PSUM_BW*COL-1:0] ofifo_dout,
  output logic                   ofifo_rd,
  output logic                   sfu_reset,
  output logic                   sfu_acc,
  output logic [PSUM_BW*COL-1:0] sfu_psum,
  output logic                   sram_wen,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ACCUM = 3'd2,
    S_RELU  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_n_s;
  logic [KIJ_W-1:0]    kij_cnt_r;
  logic [KIJ_W-1:0]    kij_last_r;
  logic [ADDR_W-1:0]   out_cnt_r;
  logic [ADDR_W-1:0]   out_last_r;
  logic                pop_s;
  logic                kij_end_s;
  logic                out_end_s;

  // A zero count behaves as one, so keep the index of the last item instead of the count.
  function automatic logic [KIJ_W-1:0] kij_last_idx(input logic [KIJ_W-1:0] n);
    return (n == {KIJ_W{1'b0}}) ? {KIJ_W{1'b0}} : n - {{(KIJ_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [ADDR_W-1:0] out_last_idx(input logic [ADDR_W-1:0] n);
    return (n == {ADDR_W{1'b0}}) ? {ADDR_W{1'b0}} : n - {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  // Control pins {sfu_reset, sfu_acc, sram_wen, busy, done} for the state being entered.
  function automatic logic [4:0] ctrl_for(input state_t s);
    case (s)
      S_IDLE:  return 5'b11000;
      S_CLR:   return 5'b10010;
      S_ACCUM: return 5'b01010;
      S_RELU:  return 5'b00010;
      S_WRITE: return 5'b01110;
      S_DONE:  return 5'b01011;
      default: return 5'b11000;
    endcase
  endfunction

  // Pops are gated by reset so an aborted run never consumes OFIFO data.
  assign pop_s     = (state_r == S_ACCUM) && !ofifo_empty && !reset;
  assign kij_end_s = (kij_cnt_r == kij_last_r);
  assign out_end_s = (out_cnt_r == out_last_r);
  assign ofifo_rd  = pop_s;
  assign sfu_psum  = pop_s ? ofifo_dout : {(PSUM_BW*COL){1'b0}};
  assign sram_addr = out_cnt_r;

  // Next-state decode.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_n_s = S_CLR;
        else       state_n_s = S_IDLE;
      end
      S_CLR:   state_n_s = S_ACCUM;
      S_ACCUM: begin
        if (pop_s && kij_end_s) state_n_s = S_RELU;
        else                    state_n_s = S_ACCUM;
      end
      S_RELU:  state_n_s = S_WRITE;
      S_WRITE: begin
        if (out_end_s) state_n_s = S_DONE;
        else           state_n_s = S_ACCUM;
      end
      S_DONE:  state_n_s = S_IDLE;
      default: state_n_s = S_IDLE;
    endcase
  end

  // State, counters, latched config and registered SFU/SRAM control pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      kij_cnt_r  <= {KIJ_W{1'b0}};
      out_cnt_r  <= {ADDR_W{1'b0}};
      kij_last_r <= {KIJ_W{1'b0}};
      out_last_r <= {ADDR_W{1'b0}};
      {sfu_reset, sfu_acc, sram_wen, busy, done} <= ctrl_for(S_IDLE);
    end else begin
      state_r <= state_n_s;
      {sfu_reset, sfu_acc, sram_wen, busy, done} <= ctrl_for(state_n_s);
      case (state_r)
        S_IDLE: begin
          if (start) begin
            kij_last_r <= kij_last_idx(num_kij);
            out_last_r <= out_last_idx(num_out);
            kij_cnt_r  <= {KIJ_W{1'b0}};
            out_cnt_r  <= {ADDR_W{1'b0}};
          end
        end
        S_ACCUM: begin
          if (pop_s) begin
            kij_cnt_r <= kij_end_s ? {KIJ_W{1'b0}} : kij_cnt_r + {{(KIJ_W-1){1'b0}}, 1'b1};
          end
        end
        S_WRITE: begin
          if (!out_end_s) out_cnt_r <= out_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfu_ctrl.sv
// Directed bench for sfu_ctrl: models the OFIFO and the accumulate/ReLU SFU and
// checks pop counts, written values/addresses and run timing.
module tb_sfu_ctrl;
  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int KIJ_W   = 4;
  localparam int ADDR_W  = 6;
  localparam int W       = PSUM_BW * COL;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [KIJ_W-1:0]  num_kij;
  logic [ADDR_W-1:0] num_out;
  logic              ofifo_empty;
  logic [W-1:0]      ofifo_dout;
  logic              ofifo_rd;
  logic              sfu_reset;
  logic              sfu_acc;
  logic [W-1:0]      sfu_psum;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic              busy;
  logic              done;

  sfu_ctrl #(.PSUM_BW(PSUM_BW), .COL(COL), .KIJ_W(KIJ_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_kij(num_kij), .num_out(num_out),
    .ofifo_empty(ofifo_empty), .ofifo_dout(ofifo_dout), .ofifo_rd(ofifo_rd),
    .sfu_reset(sfu_reset), .sfu_acc(sfu_acc), .sfu_psum(sfu_psum),
    .sram_wen(sram_wen), .sram_addr(sram_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] fifo_q[$];
  int           wr_addr[$];
  logic [W-1:0] wr_word[$];
  int           acc_m[COL];
  int           sfp_m[COL];
  int           stall_at, stall_left;
  int           cyc, pops, done_at, busy_cnt, rd_viol, stall_bad;

  task automatic clear_run();
    fifo_q.delete();
    wr_addr.delete();
    wr_word.delete();
    stall_at = -1; stall_left = 0;
    cyc = 0; pops = 0; done_at = -1; busy_cnt = 0; rd_viol = 0; stall_bad = 0;
  endtask

  // One clock: drive OFIFO, sample DUT, step the SFU model, advance past the edge.
  task automatic cycle();
    logic                      stall_now;
    logic [W-1:0]              w;
    logic signed [PSUM_BW-1:0] lane;
    stall_now = (stall_left > 0) && (pops == stall_at);
    if (stall_now) stall_left--;
    ofifo_empty = stall_now || (fifo_q.size() == 0);
    ofifo_dout  = ofifo_empty ? {COL{16'hbeef}} : fifo_q[0];
    #1;
    if (ofifo_rd && ofifo_empty) rd_viol++;
    if (stall_now && (sfu_acc !== 1'b1 || sfu_psum !== {W{1'b0}})) stall_bad++;
    if (busy) busy_cnt++;
    if (done && done_at < 0) done_at = cyc;
    if (sram_wen) begin
      w = {W{1'b0}};
      for (int l = 0; l < COL; l++) w[l*PSUM_BW +: PSUM_BW] = sfp_m[l][PSUM_BW-1:0];
      wr_addr.push_back(int'(sram_addr));
      wr_word.push_back(w);
    end
    for (int l = 0; l < COL; l++) begin
      lane = sfu_psum[l*PSUM_BW +: PSUM_BW];
      if (sfu_reset) acc_m[l] = 0;
      else if (sfu_acc) acc_m[l] = acc_m[l] + int'(lane);
      else begin
        sfp_m[l] = (acc_m[l] > 0) ? acc_m[l] : 0;
        acc_m[l] = 0;
      end
    end
    if (ofifo_rd && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_run(input int k, input int n);
    num_kij = k[KIJ_W-1:0];
    num_out = n[ADDR_W-1:0];
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_at < 0; i++) cycle();
  endtask

  task automatic test_reset();
    clear_run();
    reset = 1'b1;
    fifo_q.push_back({COL{16'd1}});
    cycle();
    cycle();
    tests++;
    if ({sfu_reset, sfu_acc, busy, done, sram_wen, ofifo_rd} !== 6'b110000) begin
      fails++;
      $display("FAIL reset_outs: got %b want 110000", {sfu_reset, sfu_acc, busy, done, sram_wen, ofifo_rd});
    end
    tests++;
    if (sfu_psum !== {W{1'b0}}) begin fails++; $display("FAIL reset_psum: got %h want 0", sfu_psum); end
    reset = 1'b0;
    cycle();
    tests++;
    if (pops !== 0) begin fails++; $display("FAIL reset_idle_pops: got %0d want 0", pops); end
  endtask

  task automatic test_basic();
    clear_run();
    for (int i = 0; i < 18; i++) fifo_q.push_back({COL{16'd3}});
    start_run(9, 2);
    wait_done(100);
    tests++;
    if (pops !== 18) begin fails++; $display("FAIL basic_pops: got %0d want 18", pops); end
    tests++;
    if (wr_addr.size() != 2 || wr_addr[0] != 0 || wr_addr[1] != 1) begin
      fails++; $display("FAIL basic_addrs: got %0d writes first %0d", wr_addr.size(), wr_addr[0]);
    end
    tests++;
    if (wr_word.size() != 2 || wr_word[0] !== {COL{16'd27}} || wr_word[1] !== {COL{16'd27}}) begin
      fails++; $display("FAIL basic_data: got %h want all lanes 27", wr_word[0]);
    end
    tests++;
    if (done_at !== 24) begin fails++; $display("FAIL basic_done_time: got %0d want 24", done_at); end
    tests++;
    if (busy_cnt !== 24) begin fails++; $display("FAIL basic_busy_cycles: got %0d want 24", busy_cnt); end
    tests++;
    if (busy !== 1'b0 || rd_viol !== 0) begin
      fails++; $display("FAIL basic_after: busy %b rd_viol %0d want 0/0", busy, rd_viol);
    end
  endtask

  task automatic test_negative();
    logic [W-1:0] w;
    logic [W-1:0] exp_w;
    clear_run();
    w = {W{1'b0}}; w[15:0] = 16'hfffb; w[31:16] = 16'h0004; fifo_q.push_back(w);
    w = {W{1'b0}}; w[15:0] = 16'h0002; w[31:16] = 16'h0004; fifo_q.push_back(w);
    w = {W{1'b0}}; w[15:0] = 16'hffff; w[31:16] = 16'h0004; fifo_q.push_back(w);
    exp_w = {W{1'b0}}; exp_w[31:16] = 16'd12;
    start_run(3, 1);
    wait_done(50);
    tests++;
    if (wr_word.size() != 1 || wr_word[0] !== exp_w) begin
      fails++; $display("FAIL neg_data: got %h want %h", wr_word[0], exp_w);
    end
    tests++;
    if (done_at !== 7) begin fails++; $display("FAIL neg_done_time: got %0d want 7", done_at); end
  endtask

  task automatic test_stall();
    clear_run();
    for (int i = 0; i < 4; i++) fifo_q.push_back({COL{16'd1}});
    stall_at = 2; stall_left = 3;
    start_run(4, 1);
    wait_done(50);
    tests++;
    if (wr_word.size() != 1 || wr_word[0] !== {COL{16'd4}}) begin
      fails++; $display("FAIL stall_data: got %h want all lanes 4", wr_word[0]);
    end
    tests++;
    if (done_at !== 11) begin fails++; $display("FAIL stall_done_time: got %0d want 11", done_at); end
    tests++;
    if (stall_bad !== 0) begin fails++; $display("FAIL stall_ctrl: got %0d bad cycles want 0", stall_bad); end
    tests++;
    if (rd_viol !== 0) begin fails++; $display("FAIL stall_rd_empty: got %0d want 0", rd_viol); end
  endtask

  task automatic test_zero();
    clear_run();
    for (int i = 0; i < 2; i++) fifo_q.push_back({COL{16'd7}});
    start_run(0, 0);
    wait_done(50);
    tests++;
    if (pops !== 1) begin fails++; $display("FAIL zero_pops: got %0d want 1", pops); end
    tests++;
    if (wr_addr.size() != 1 || wr_addr[0] != 0 || wr_word[0] !== {COL{16'd7}}) begin
      fails++; $display("FAIL zero_write: got %0d writes data %h want 1 write of 7s", wr_addr.size(), wr_word[0]);
    end
    tests++;
    if (done_at !== 5) begin fails++; $display("FAIL zero_done_time: got %0d want 5", done_at); end
  endtask

  task automatic test_reset_mid();
    clear_run();
    for (int i = 0; i < 9; i++) fifo_q.push_back({COL{16'd2}});
    start_run(9, 1);
    for (int i = 0; i < 50 && pops < 5; i++) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    tests++;
    if (sfu_reset !== 1'b1 || busy !== 1'b0 || sram_wen !== 1'b0) begin
      fails++; $display("FAIL rstmid_state: reset %b busy %b wen %b want 1/0/0", sfu_reset, busy, sram_wen);
    end
    tests++;
    if (pops !== 5 || fifo_q.size() != 4) begin
      fails++; $display("FAIL rstmid_fifo: pops %0d left %0d want 5/4", pops, fifo_q.size());
    end
    for (int i = 0; i < 3; i++) cycle();
    tests++;
    if (wr_word.size() != 0) begin fails++; $display("FAIL rstmid_nowrite: got %0d writes want 0", wr_word.size()); end
    clear_run();
    for (int i = 0; i < 2; i++) fifo_q.push_back({COL{16'd5}});
    start_run(2, 1);
    wait_done(50);
    tests++;
    if (wr_word.size() != 1 || wr_word[0] !== {COL{16'd10}}) begin
      fails++; $display("FAIL rstmid_fresh: got %h want all lanes 10", wr_word[0]);
    end
    tests++;
    if (done_at !== 6) begin fails++; $display("FAIL rstmid_done_time: got %0d want 6", done_at); end
  endtask

  task automatic test_start_busy();
    clear_run();
    for (int i = 0; i < 10; i++) fifo_q.push_back({COL{16'd1}});
    start_run(2, 3);
    for (int i = 0; i < 3; i++) cycle();
    num_kij = 4'd5;
    num_out = 6'd1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    wait_done(100);
    tests++;
    if (wr_addr.size() != 3 || wr_addr[0] != 0 || wr_addr[1] != 1 || wr_addr[2] != 2) begin
      fails++; $display("FAIL busy_addrs: got %0d writes want 3 at 0,1,2", wr_addr.size());
    end
    tests++;
    if (wr_word.size() != 3 || wr_word[2] !== {COL{16'd2}} || wr_word[0] !== {COL{16'd2}}) begin
      fails++; $display("FAIL busy_data: got %h want all lanes 2", wr_word[0]);
    end
    tests++;
    if (pops !== 6 || fifo_q.size() != 4) begin
      fails++; $display("FAIL busy_pops: pops %0d left %0d want 6/4", pops, fifo_q.size());
    end
    tests++;
    if (done_at !== 14) begin fails++; $display("FAIL busy_done_time: got %0d want 14", done_at); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_kij = 4'd0; num_out = 6'd0;
    ofifo_empty = 1'b1; ofifo_dout = {W{1'b0}};
    for (int l = 0; l < COL; l++) begin acc_m[l] = 0; sfp_m[l] = 0; end
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_negative();
    test_stall();
    test_zero();
    test_reset_mid();
    test_start_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
